// File: rtl/route_1to2_if.sv
// Shared constants and the message handshake bus for route_1to2.
//   route_1to2_pkg : compare-operator codes, boolean codes, default field widths.
//   route_1to2_if  : src/dst/dat/red message fields plus four-phase req/ack.
//     master modport drives the fields and req and receives ack;
//     slave modport receives the fields and req and drives ack.
package route_1to2_pkg;
  localparam int unsigned NS_GT_OP = 0;
  localparam int unsigned NS_GE_OP = 1;
  localparam int unsigned NS_LT_OP = 2;
  localparam int unsigned NS_LE_OP = 3;
  localparam int unsigned NS_EQ_OP = 4;
  localparam int unsigned NS_NE_OP = 5;

  localparam bit NS_FALSE = 1'b0;
  localparam bit NS_TRUE  = 1'b1;

  localparam int unsigned NS_ADDRESS_SIZE = 8;
  localparam int unsigned NS_DATA_SIZE    = 32;
  localparam int unsigned NS_REDUN_SIZE   = 4;
endpackage

interface route_1to2_if #(
  parameter int unsigned ASZ = route_1to2_pkg::NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = route_1to2_pkg::NS_DATA_SIZE,
  parameter int unsigned RSZ = route_1to2_pkg::NS_REDUN_SIZE
);
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output src, dst, dat, red, req, input ack);
  modport slave  (input src, dst, dat, red, req, output ack);
endinterface

// File: rtl/route_1to2.sv
// route_1to2: one-entry buffered 1-to-2 message router with four-phase handshakes.
// A message accepted on i0 is routed by comparing its dst against one reference
// (or a range of two) and offered on o0 when the test is true, o1 otherwise.
// Ports:
//   clk   - sole clock, posedge
//   reset - asynchronous, active-high
//   i0    - input message bus (slave modport)
//   o0/o1 - output message buses (master modports); both carry the buffered message
//   err   - sticky redundancy error flag
// Optional feature: define ROUTE_1TO2_REDUN_CHK_EN to check the red field and drop
// bad messages; otherwise every message passes and err is tied low.
module route_1to2
  import route_1to2_pkg::*;
#(
  parameter int unsigned OPER_1    = NS_GT_OP,
  parameter int unsigned REF_VAL_1 = 0,
  parameter bit          IS_RANGE  = NS_FALSE,
  parameter int unsigned OPER_2    = NS_GT_OP,
  parameter int unsigned REF_VAL_2 = 0,
  parameter int unsigned ASZ       = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ       = NS_DATA_SIZE,
  parameter int unsigned RSZ       = NS_REDUN_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  route_1to2_if.slave  i0,
  route_1to2_if.master o0,
  route_1to2_if.master o1,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT_ACK, WAIT_REL} state_t;

  state_t         state, state_d;
  logic [ASZ-1:0] buf_src, buf_dst;
  logic [DSZ-1:0] buf_dat;
  logic [RSZ-1:0] buf_red;
  logic           sel0, sel0_d;
  logic           ack_q, ack_d;
  logic           req0_q, req0_d;
  logic           req1_q, req1_d;
  logic           accept, sel_ack, route_hit, redun_ok;

  // Generic unsigned compare selected by operator code
  function automatic logic op_cmp(input int unsigned op, input logic [ASZ-1:0] a,
                                  input logic [ASZ-1:0] b);
    logic r;
    case (op)
      NS_GT_OP: r = (a > b);
      NS_GE_OP: r = (a >= b);
      NS_LT_OP: r = (a < b);
      NS_LE_OP: r = (a <= b);
      NS_EQ_OP: r = (a == b);
      NS_NE_OP: r = (a != b);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  assign route_hit = IS_RANGE ? (op_cmp(OPER_1, buf_dst, ASZ'(REF_VAL_1)) &&
                                 op_cmp(OPER_2, buf_dst, ASZ'(REF_VAL_2)))
                              : op_cmp(OPER_1, buf_dst, ASZ'(REF_VAL_1));

  // Accept only a fresh request: ack must have dropped since the last message
  assign accept  = (state == IDLE) && i0.req && !ack_q;
  // Acks from the port not selected never influence the FSM
  assign sel_ack = sel0 ? o0.ack : o1.ack;

`ifdef ROUTE_1TO2_REDUN_CHK_EN
  localparam int unsigned CAT_W  = 2 * ASZ + DSZ;
  localparam int unsigned NCHUNK = (CAT_W + RSZ - 1) / RSZ;

  // XOR-fold of {src,dst,dat} into RSZ-bit chunks, dat in the low chunk
  function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] s,
                                                input logic [ASZ-1:0] d,
                                                input logic [DSZ-1:0] x);
    logic [NCHUNK*RSZ-1:0] v;
    logic [RSZ-1:0]        r;
    v = (NCHUNK * RSZ)'({s, d, x});
    r = '0;
    for (int i = 0; i < int'(NCHUNK); i++) r ^= v[i*RSZ +: RSZ];
    return r;
  endfunction

  assign redun_ok = (calc_redun(buf_src, buf_dst, buf_dat) == buf_red);

  // Sticky error: set on any dropped message, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            err <= 1'b0;
    else if (state == CHECK && !redun_ok) err <= 1'b1;
  end
`else
  assign redun_ok = 1'b1;
  assign err      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (accept) state_d = CHECK;
      CHECK:    state_d = redun_ok ? SEND : IDLE;
      SEND:     state_d = WAIT_ACK;
      WAIT_ACK: if (sel_ack) state_d = WAIT_REL;
      WAIT_REL: if (!sel_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values for the registered handshake outputs and route select
  always_comb begin
    ack_d  = i0.req && (ack_q || accept);
    req0_d = req0_q;
    req1_d = req1_q;
    sel0_d = sel0;
    case (state)
      CHECK: sel0_d = route_hit;
      SEND: begin
        req0_d = sel0;
        req1_d = !sel0;
      end
      WAIT_ACK: if (sel_ack) begin
        req0_d = 1'b0;
        req1_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Handshake output registers; async reset drops req immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q  <= 1'b0;
      req0_q <= 1'b0;
      req1_q <= 1'b0;
      sel0   <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      req0_q <= req0_d;
      req1_q <= req1_d;
      sel0   <= sel0_d;
    end
  end

  // One-entry message buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_src <= '0;
      buf_dst <= '0;
      buf_dat <= '0;
      buf_red <= '0;
    end else if (accept) begin
      buf_src <= i0.src;
      buf_dst <= i0.dst;
      buf_dat <= i0.dat;
      buf_red <= i0.red;
    end
  end

  assign i0.ack = ack_q;
  assign o0.src = buf_src;
  assign o0.dst = buf_dst;
  assign o0.dat = buf_dat;
  assign o0.red = buf_red;
  assign o0.req = req0_q;
  assign o1.src = buf_src;
  assign o1.dst = buf_dst;
  assign o1.dat = buf_dat;
  assign o1.red = buf_red;
  assign o1.req = req1_q;

endmodule

// File: tb/tb_route_1to2.sv
// Scoreboard bench for route_1to2: DUT 0 routes on dst > 3, DUT 1 on 2 < dst < 6.
module tb_route_1to2;
  import route_1to2_pkg::*;

  typedef struct packed {
    logic       port;
    logic [7:0] src;
    logic [7:0] dst;
    logic [31:0] dat;
    logic [3:0] red;
  } msg_t;

  logic clk;
  logic rst [2];

  logic [7:0]  drv_src [2];
  logic [7:0]  drv_dst [2];
  logic [31:0] drv_dat [2];
  logic [3:0]  drv_red [2];
  logic        drv_req [2];
  logic        i_ack   [2];
  logic        err_w   [2];

  logic        o_req [4];
  logic [7:0]  o_src [4];
  logic [7:0]  o_dst [4];
  logic [31:0] o_dat [4];
  logic [3:0]  o_red [4];
  bit          stall [4];
  bit          spur  [4];

  msg_t exp_q [2][$];
  int   n_cmp;
  int   n_bad;

  route_1to2_if in_if  [2] ();
  route_1to2_if out_if [4] ();

  route_1to2 #(.OPER_1(NS_GT_OP), .REF_VAL_1(3), .IS_RANGE(NS_FALSE),
               .OPER_2(NS_GT_OP), .REF_VAL_2(0)) dut0 (
    .clk(clk), .reset(rst[0]), .i0(in_if[0]), .o0(out_if[0]), .o1(out_if[1]), .err(err_w[0]));

  route_1to2 #(.OPER_1(NS_GT_OP), .REF_VAL_1(2), .IS_RANGE(NS_TRUE),
               .OPER_2(NS_LT_OP), .REF_VAL_2(6)) dut1 (
    .clk(clk), .reset(rst[1]), .i0(in_if[1]), .o0(out_if[2]), .o1(out_if[3]), .err(err_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference routing rule per DUT; returns the output port index
  function automatic logic exp_port(input int d, input logic [7:0] dst);
    if (d == 0) return (dst > 8'd3) ? 1'b0 : 1'b1;
    return (dst > 8'd2 && dst < 8'd6) ? 1'b0 : 1'b1;
  endfunction

  // Redundancy nibble: XOR of all 4-bit groups of {src,dst,dat}
  function automatic logic [3:0] model_red(input msg_t m);
    logic [47:0] x;
    logic [3:0]  r;
    x = {m.src, m.dst, m.dat};
    r = 4'd0;
    repeat (12) begin
      r ^= x[3:0];
      x = x >> 4;
    end
    return r;
  endfunction

  function automatic msg_t mk_msg(input logic [7:0] dst);
    msg_t m;
    m.port = 1'b0;
    m.src  = 8'($urandom);
    m.dst  = dst;
    m.dat  = 32'($urandom);
    m.red  = 4'd0;
    m.red  = model_red(m);
    return m;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_in
    assign in_if[g].src = drv_src[g];
    assign in_if[g].dst = drv_dst[g];
    assign in_if[g].dat = drv_dat[g];
    assign in_if[g].red = drv_red[g];
    assign in_if[g].req = drv_req[g];
    assign i_ack[g]     = in_if[g].ack;
  end

  // Output sinks: random-latency four-phase responders, stallable, with spurious ack
  for (genvar g = 0; g < 4; g++) begin : g_out
    logic ack_r;
    assign o_req[g]      = out_if[g].req;
    assign o_src[g]      = out_if[g].src;
    assign o_dst[g]      = out_if[g].dst;
    assign o_dat[g]      = out_if[g].dat;
    assign o_red[g]      = out_if[g].red;
    assign out_if[g].ack = ack_r;
    initial begin
      ack_r = 1'b0;
      forever begin
        @(negedge clk);
        if (o_req[g] && !stall[g]) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          ack_r = 1'b1;
          for (int t = 0; t < 200 && o_req[g]; t++) @(negedge clk);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          ack_r = 1'b0;
        end else begin
          ack_r = spur[g];
        end
      end
    end
  end

  // Monitors: pop the scoreboard on each new req and hold the message while req stays high
  for (genvar d = 0; d < 2; d++) begin : g_mon
    initial begin
      bit   p0, p1, r0, r1;
      int   pi, po;
      msg_t cur;
      p0 = 1'b0;
      p1 = 1'b0;
      cur = '0;
      forever begin
        @(negedge clk);
        r0 = o_req[2*d];
        r1 = o_req[2*d+1];
        pi = r1 ? 2*d+1 : 2*d;
        po = r1 ? 2*d : 2*d+1;
        if (r0 || r1) check("req_onehot", 64'(r0 & r1), 64'd0);
        if ((r0 && !p0) || (r1 && !p1)) begin
          if (exp_q[d].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_req: dut %0d port %0d raised req with empty scoreboard at %0t",
                     d, r1, $time);
          end else begin
            cur = exp_q[d].pop_front();
            check("route_port", 64'(r1), 64'(cur.port));
            check("out_src", 64'(o_src[pi]), 64'(cur.src));
            check("out_dst", 64'(o_dst[pi]), 64'(cur.dst));
            check("out_dat", 64'(o_dat[pi]), 64'(cur.dat));
            check("out_red", 64'(o_red[pi]), 64'(cur.red));
            check("mirror_dat", 64'(o_dat[po]), 64'(cur.dat));
          end
        end else if ((r0 && p0) || (r1 && p1)) begin
          check("stable_dst", 64'(o_dst[pi]), 64'(cur.dst));
          check("stable_dat", 64'(o_dat[pi]), 64'(cur.dat));
        end
        p0 = r0;
        p1 = r1;
      end
    end
  end

  // Wait until DUT d has nothing queued and both reqs have stayed low a while
  task automatic wait_idle(input int d);
    int quiet;
    int t;
    quiet = 0;
    t = 0;
    while (quiet < 6 && t < 1000) begin
      @(negedge clk);
      t++;
      if (exp_q[d].size() == 0 && !o_req[2*d] && !o_req[2*d+1]) quiet++;
      else quiet = 0;
    end
    if (quiet < 6) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: dut %0d did not go idle at %0t", d, $time);
    end
  endtask

  // Four-phase send on DUT d; expected output pushed at acceptance
  task automatic send(input int d, input msg_t m, input bit drop, input bit lat);
    msg_t e;
    int   t;
    if (lat) wait_idle(d);
    drv_src[d] = m.src;
    drv_dst[d] = m.dst;
    drv_dat[d] = m.dat;
    drv_red[d] = m.red;
    drv_req[d] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!i_ack[d] && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("in_ack_rise", 64'(i_ack[d]), 64'd1);
    e = m;
    e.port = exp_port(d, m.dst);
    if (!drop) exp_q[d].push_back(e);
    if (lat && !drop) begin
      @(negedge clk);
      check("lat_edge_n1", 64'(o_req[2*d] | o_req[2*d+1]), 64'd0);
      @(negedge clk);
      check("lat_edge_n2", 64'(o_req[2*d+int'(e.port)]), 64'd1);
      check("lat_other_low", 64'(o_req[2*d+1-int'(e.port)]), 64'd0);
    end
    drv_req[d] = 1'b0;
    t = 0;
    @(negedge clk);
    while (i_ack[d] && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("in_ack_fall", 64'(i_ack[d]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    msg_t m;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 4; i++) begin
      stall[i] = 1'b0;
      spur[i]  = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      drv_src[d] = 8'd0;
      drv_dst[d] = 8'd0;
      drv_dat[d] = 32'd0;
      drv_red[d] = 4'd0;
      drv_req[d] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ack", 64'(i_ack[d]), 64'd0);
      check("rst_err", 64'(err_w[d]), 64'd0);
    end
    for (int g = 0; g < 4; g++) begin
      check("rst_req", 64'(o_req[g]), 64'd0);
      check("rst_dat", 64'(o_dat[g]), 64'd0);
      check("rst_src", 64'(o_src[g]), 64'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    // GT 3: above, equal and below the reference
    send(0, mk_msg(8'd5), 1'b0, 1'b1);
    send(0, mk_msg(8'd3), 1'b0, 1'b1);
    send(0, mk_msg(8'd2), 1'b0, 1'b1);

    // Range 2 < dst < 6 sweep
    for (int v = 1; v <= 7; v++) send(1, mk_msg(8'(v)), 1'b0, 1'b1);

    // Ack on the non-selected port is ignored
    wait_idle(0);
    stall[0] = 1'b1;
    send(0, mk_msg(8'd7), 1'b0, 1'b1);
    spur[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("spur_hold_req0", 64'(o_req[0]), 64'd1);
      check("spur_req1_low", 64'(o_req[1]), 64'd0);
    end
    spur[1] = 1'b0;
    @(negedge clk);
    stall[0] = 1'b0;
    wait_idle(0);

    // Backpressure: second message waits while port 0 is held
    stall[0] = 1'b1;
    send(0, mk_msg(8'd5), 1'b0, 1'b1);
    fork
      send(0, mk_msg(8'd0), 1'b0, 1'b0);
    join_none
    repeat (10) begin
      @(negedge clk);
      check("bp_no_ack", 64'(i_ack[0]), 64'd0);
      check("bp_req0_held", 64'(o_req[0]), 64'd1);
    end
    stall[0] = 1'b0;
    wait fork;
    wait_idle(0);

    // Redundancy error handling
    m = mk_msg(8'd6);
    m.red = m.red ^ 4'd1;
`ifdef ROUTE_1TO2_REDUN_CHK_EN
    send(0, m, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("err_set", 64'(err_w[0]), 64'd1);
    send(0, mk_msg(8'd9), 1'b0, 1'b1);
    wait_idle(0);
    check("err_sticky", 64'(err_w[0]), 64'd1);
`else
    send(0, m, 1'b0, 1'b1);
    wait_idle(0);
    check("err_tied_low", 64'(err_w[0]), 64'd0);
`endif

    // Reset while waiting for ack drops req without a clock edge
    stall[0] = 1'b1;
    send(0, mk_msg(8'd6), 1'b0, 1'b1);
    @(negedge clk);
    check("pre_rst_req0", 64'(o_req[0]), 64'd1);
    rst[0] = 1'b1;
    #1;
    check("async_rst_req0", 64'(o_req[0]), 64'd0);
    check("async_rst_dat", 64'(o_dat[0]), 64'd0);
    check("async_rst_err", 64'(err_w[0]), 64'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    stall[0] = 1'b0;
    send(0, mk_msg(8'd4), 1'b0, 1'b1);
    send(0, mk_msg(8'd1), 1'b0, 1'b1);

    // Randomized traffic on both DUTs
    for (int i = 0; i < 30; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 7) == 0) m = mk_msg(8'($urandom));
        else m = mk_msg(8'($urandom_range(0, 9)));
        send(d, m, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    wait_idle(0);
    wait_idle(1);
    check("sb_empty_0", 64'(exp_q[0].size()), 64'd0);
    check("sb_empty_1", 64'(exp_q[1].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
